// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin encoding, price table and datapath widths.
package vend_pkg;

    localparam int CREDIT_W = 5;
    localparam int SLOT_N   = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_CREDIT   = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [CREDIT_W-1:0] PRICE [SLOT_N] = '{5'd3, 5'd4, 5'd5, 5'd6};

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] slot);
        return PRICE[slot];
    endfunction

    // Value in units of an encoded coin; invalid and empty codes are worth 0.
    function automatic logic [1:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_ONE: return 2'd1;
            COIN_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Customer/dispenser-facing signal bundle of the vending controller.
interface vend_if;
    import vend_pkg::*;

    logic [1:0]          coin;
    logic                sel_valid;
    logic [1:0]          sel;
    logic                cancel;
    logic                restock;
    logic                disp_ack;
    logic                disp_req;
    logic [1:0]          disp_slot;
    logic                change_coin;
    logic [CREDIT_W-1:0] credit;
    logic [SLOT_N-1:0]   sold_out;
    logic                busy;
    logic                coin_reject;
    logic                sel_error;
    logic                disp_fault;

    modport master (
        output coin, sel_valid, sel, cancel, restock, disp_ack,
        input  disp_req, disp_slot, change_coin, credit, sold_out,
               busy, coin_reject, sel_error, disp_fault
    );

    modport slave (
        input  coin, sel_valid, sel, cancel, restock, disp_ack,
        output disp_req, disp_slot, change_coin, credit, sold_out,
               busy, coin_reject, sel_error, disp_fault
    );

endinterface

// File: rtl/vend_stock.sv
// Per-slot stock counters with decrement, bulk restock and sold-out flags.
module vend_stock
    import vend_pkg::*;
#(
    parameter int STOCK_INIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec,
    input  logic [1:0]        dec_slot,
    input  logic              restock,
    output logic [SLOT_N-1:0] sold_out
);

    localparam logic [2:0] INIT = 3'(STOCK_INIT);

    logic [SLOT_N-1:0][2:0] stock_q;

    // Reload all slots on restock, otherwise count one item out on dispense.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stock_q <= {SLOT_N{INIT}};
        end else begin
            for (int i = 0; i < SLOT_N; i++) begin
                if (restock) begin
                    stock_q[i] <= INIT;
                end else if (dec && dec_slot == 2'(i) && stock_q[i] != 3'd0) begin
                    stock_q[i] <= stock_q[i] - 3'd1;
                end
            end
        end
    end

    // A slot is sold out exactly when its counter is empty.
    always_comb begin
        sold_out = '0;
        for (int i = 0; i < SLOT_N; i++) begin
            sold_out[i] = (stock_q[i] == 3'd0);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: accumulates credit, sells from four slots through a
// request/acknowledge dispenser and refunds change one unit per cycle.
module vend_controller
    import vend_pkg::*;
#(
    parameter int STOCK_INIT  = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic  clk,
    input  logic  rst,
    vend_if.slave bus
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    vend_state_t         state;
    logic [CREDIT_W-1:0] credit_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [1:0]          slot_q;
    logic                disp_req_q;
    logic                busy_q;
    logic                change_q;
    logic                reject_q;
    logic                sel_err_q;
    logic                fault_q;
    logic [SLOT_N-1:0]   sold_out;
    logic                stock_dec;
    logic                stock_reload;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;

    // Saturating credit add; a refund can never push credit past the maximum.
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [CREDIT_W-1:0] b);
        logic [CREDIT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : s[CREDIT_W-1:0];
    endfunction

    assign stock_dec    = (state == ST_DISPENSE) && bus.disp_ack;
    assign stock_reload = (state == ST_CREDIT) && bus.restock;

    vend_stock #(.STOCK_INIT(STOCK_INIT)) u_stock (
        .clk      (clk),
        .rst      (rst),
        .dec      (stock_dec),
        .dec_slot (slot_q),
        .restock  (stock_reload),
        .sold_out (sold_out)
    );

    // Decode the coin sum and selection admissibility for the CREDIT state.
    always_comb begin
        coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(bus.coin));
        sel_price = price_of(bus.sel);
        sel_ok    = (credit_q >= sel_price) && !sold_out[bus.sel];
    end

    // Main FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_CREDIT;
            credit_q   <= '0;
            tmo_cnt    <= '0;
            slot_q     <= '0;
            disp_req_q <= 1'b0;
            busy_q     <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            sel_err_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            change_q  <= 1'b0;
            reject_q  <= 1'b0;
            sel_err_q <= 1'b0;
            fault_q   <= 1'b0;
            case (state)
                ST_CREDIT: begin
                    if (bus.cancel) begin
                        reject_q <= (bus.coin != COIN_NONE);
                        if (credit_q != '0) begin
                            state  <= ST_CHANGE;
                            busy_q <= 1'b1;
                        end
                    end else if (bus.sel_valid) begin
                        reject_q <= (bus.coin != COIN_NONE);
                        if (sel_ok) begin
                            credit_q   <= credit_q - sel_price;
                            slot_q     <= bus.sel;
                            tmo_cnt    <= '0;
                            disp_req_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= ST_DISPENSE;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end else if (bus.coin != COIN_NONE) begin
                        if (bus.coin == COIN_BAD || coin_sum > {1'b0, CREDIT_MAX}) begin
                            reject_q <= 1'b1;
                        end else begin
                            credit_q <= coin_sum[CREDIT_W-1:0];
                        end
                    end
                end
                ST_DISPENSE: begin
                    reject_q  <= (bus.coin != COIN_NONE);
                    sel_err_q <= bus.sel_valid;
                    if (bus.disp_ack) begin
                        disp_req_q <= 1'b0;
                        if (credit_q != '0) begin
                            state <= ST_CHANGE;
                        end else begin
                            state  <= ST_CREDIT;
                            busy_q <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Dispenser never answered: give the money back.
                        disp_req_q <= 1'b0;
                        fault_q    <= 1'b1;
                        credit_q   <= sat_add(credit_q, price_of(slot_q));
                        state      <= ST_CHANGE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CHANGE: begin
                    reject_q  <= (bus.coin != COIN_NONE);
                    sel_err_q <= bus.sel_valid;
                    if (credit_q != '0) begin
                        change_q <= 1'b1;
                        credit_q <= credit_q - CREDIT_W'(1);
                        if (credit_q == CREDIT_W'(1)) begin
                            state  <= ST_CREDIT;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        state  <= ST_CREDIT;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_CREDIT;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_slot   = slot_q;
    assign bus.change_coin = change_q;
    assign bus.credit      = credit_q;
    assign bus.sold_out    = sold_out;
    assign bus.busy        = busy_q;
    assign bus.coin_reject = reject_q;
    assign bus.sel_error   = sel_err_q;
    assign bus.disp_fault  = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed purchase/refund scenarios followed by
// random transactions, all checked against a transaction-level model.
module tb_vend_controller;

    localparam int STOCK_INIT  = 7;
    localparam int ACK_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;

    vend_if bus ();

    vend_controller #(.STOCK_INIT(STOCK_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: credit in units and items left per slot.
    int m_credit;
    int m_stock [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.coin      = 2'b00;
        bus.sel_valid = 1'b0;
        bus.sel       = 2'd0;
        bus.cancel    = 1'b0;
        bus.restock   = 1'b0;
        bus.disp_ack  = 1'b0;
    endtask

    function automatic logic [3:0] exp_sold();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_stock[i] == 0);
        return r;
    endfunction

    function automatic int price(input int slot);
        return 3 + slot;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_credit"}, bus.credit, m_credit);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_disp_req"}, bus.disp_req, 0);
        chk({tag, "_sold_out"}, bus.sold_out, exp_sold());
    endtask

    // Drains the refund: every cycle of the drain must carry one pulse.
    task automatic collect_change(input string tag);
        int n = 0;
        int t = 0;
        int expn = m_credit;
        while (bus.busy === 1'b1 && t < 80) begin
            tick();
            t++;
            if (bus.change_coin === 1'b1) n++;
        end
        m_credit = 0;
        chk({tag, "_pulses"}, n, expn);
        chk({tag, "_contiguous"}, t, expn);
        check_idle(tag);
    endtask

    task automatic coin_txn(input logic [1:0] c, input logic stray_ack);
        int v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
        logic rej = (c == 2'b11) || (m_credit + v > 31);
        bus.coin     = c;
        bus.disp_ack = stray_ack;
        tick();
        clear_inputs();
        if (!rej) m_credit += v;
        chk("coin_reject", bus.coin_reject, rej);
        check_idle("coin");
    endtask

    task automatic cancel_txn(input logic [1:0] c);
        bus.cancel    = 1'b1;
        bus.coin      = c;
        bus.sel_valid = 1'b1;
        bus.sel       = 2'd0;
        tick();
        clear_inputs();
        chk("cancel_coin_reject", bus.coin_reject, (c != 2'b00));
        chk("cancel_sel_error", bus.sel_error, 0);
        chk("cancel_busy", bus.busy, (m_credit != 0));
        collect_change("cancel");
    endtask

    task automatic restock_txn();
        bus.restock = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
        check_idle("restock");
    endtask

    // Purchase: ack after d waiting cycles (timeout=0) or never (timeout=1).
    task automatic buy(input int slot, input logic timeout, input int d, input logic poke);
        int p = price(slot);
        int n;
        int t;
        logic ok = (m_credit >= p) && (m_stock[slot] > 0);
        bus.sel_valid = 1'b1;
        bus.sel       = 2'(slot);
        tick();
        clear_inputs();
        if (!ok) begin
            chk("sel_error", bus.sel_error, 1);
            check_idle("refused");
            return;
        end
        m_credit -= p;
        chk("sel_accept", bus.sel_error, 0);
        chk("sel_credit", bus.credit, m_credit);
        chk("sel_disp_req", bus.disp_req, 1);
        chk("sel_disp_slot", bus.disp_slot, slot);
        chk("sel_busy", bus.busy, 1);
        if (!timeout) begin
            for (int k = 0; k < d; k++) begin
                if (poke && k == 0) begin
                    bus.coin      = 2'b01;
                    bus.sel_valid = 1'b1;
                    bus.cancel    = 1'b1;
                end
                tick();
                clear_inputs();
                if (poke && k == 0) begin
                    chk("disp_coin_reject", bus.coin_reject, 1);
                    chk("disp_sel_error", bus.sel_error, 1);
                    chk("disp_credit_hold", bus.credit, m_credit);
                end
                chk("disp_hold", bus.disp_req, 1);
                chk("disp_slot_hold", bus.disp_slot, slot);
            end
            bus.disp_ack = 1'b1;
            tick();
            clear_inputs();
            m_stock[slot]--;
            chk("ack_disp_req", bus.disp_req, 0);
            chk("ack_fault", bus.disp_fault, 0);
            chk("ack_sold_out", bus.sold_out, exp_sold());
            chk("ack_busy", bus.busy, (m_credit != 0));
        end else begin
            n = 1;
            t = 0;
            while (bus.disp_fault !== 1'b1 && t < 40) begin
                tick();
                t++;
                if (bus.disp_req === 1'b1) n++;
            end
            m_credit += p;
            chk("timeout_fault", bus.disp_fault, 1);
            chk("timeout_len", n, ACK_TIMEOUT);
            chk("timeout_credit", bus.credit, m_credit);
            chk("timeout_disp_req", bus.disp_req, 0);
            chk("timeout_sold_out", bus.sold_out, exp_sold());
        end
        collect_change("buy");
    endtask

    initial begin
        int r;
        int d;
        clear_inputs();
        model_reset();

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_credit", bus.credit, 0);
        chk("rst_disp_req", bus.disp_req, 0);
        chk("rst_disp_slot", bus.disp_slot, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sold_out", bus.sold_out, 0);
        chk("rst_pulses", {bus.change_coin, bus.coin_reject, bus.sel_error, bus.disp_fault}, 0);
        rst = 1'b1;
        tick();
        check_idle("post_rst");

        // 2+2+1 units, buy slot 2, ack on the third dispense cycle
        coin_txn(2'b10, 1'b0);
        coin_txn(2'b10, 1'b1);
        coin_txn(2'b01, 1'b0);
        chk("five_units", bus.credit, 5);
        buy(2, 1'b0, 2, 1'b1);
        chk("stock2", dut.u_stock.stock_q[2], 6);

        // Credit 7, buy slot 0, 4 units change
        coin_txn(2'b10, 1'b0);
        coin_txn(2'b10, 1'b0);
        coin_txn(2'b10, 1'b0);
        coin_txn(2'b01, 1'b0);
        buy(0, 1'b0, 1, 1'b0);

        // Credit ceiling and full refund of 30 units
        for (int i = 0; i < 15; i++) coin_txn(2'b10, 1'b0);
        coin_txn(2'b10, 1'b0);
        chk("ceiling_credit", bus.credit, 30);
        coin_txn(2'b11, 1'b0);
        cancel_txn(2'b00);

        // Insufficient credit, then cancel with a losing coin
        coin_txn(2'b10, 1'b0);
        buy(1, 1'b0, 0, 1'b0);
        chk("short_credit", bus.credit, 2);
        cancel_txn(2'b01);
        cancel_txn(2'b00);

        // Dispenser timeout on slot 3
        for (int i = 0; i < 3; i++) coin_txn(2'b10, 1'b0);
        buy(3, 1'b1, 0, 1'b0);
        chk("stock3", dut.u_stock.stock_q[3], 7);

        // Reset in the middle of a refund
        for (int i = 0; i < 5; i++) coin_txn(2'b10, 1'b0);
        bus.cancel = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_credit", bus.credit, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_change", bus.change_coin, 0);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_refund", bus.change_coin, 0);
        end

        // Sell slot 0 out, refuse it when empty, then restock
        for (int i = 0; i < 7; i++) begin
            coin_txn(2'b10, 1'b0);
            coin_txn(2'b01, 1'b0);
            buy(0, 1'b0, 0, 1'b0);
        end
        chk("sold_out0", bus.sold_out[0], 1);
        coin_txn(2'b10, 1'b0);
        coin_txn(2'b01, 1'b0);
        buy(0, 1'b0, 0, 1'b0);
        cancel_txn(2'b00);
        restock_txn();
        chk("restocked0", dut.u_stock.stock_q[0], 7);

        // Random transactions
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                coin_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            end else if (r <= 6) begin
                d = $urandom_range(0, ACK_TIMEOUT - 2);
                buy($urandom_range(0, 3), ($urandom_range(0, 7) == 0), d,
                    (d > 0) && ($urandom_range(0, 1) == 1));
            end else if (r == 7) begin
                cancel_txn(2'($urandom_range(0, 3)));
            end else if (r == 8) begin
                restock_txn();
            end else begin
                tick();
                check_idle("idle");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter STOCK_INIT, default 7, initial and restock quantity per slot (3-bit counters).
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles disp_req waits for disp_ack.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-low: rst==0 at a rising clk edge resets the block.
REQ-005 coin  in  2  coin this cycle: 00 none, 01 = 1 unit, 10 = 2 units, 11 = invalid.
REQ-006 sel_valid  in  1  product selection strobe, one cycle.
REQ-007 sel  in  2  slot index 0..3, valid with sel_valid.
REQ-008 cancel  in  1  request refund of all credit.
REQ-009 restock  in  1  reload every slot to STOCK_INIT.
REQ-010 disp_ack  in  1  dispenser completion acknowledge.
REQ-011 disp_req  out  1  dispense request, level, held until ack or timeout.
REQ-012 disp_slot  out  2  slot being dispensed, stable while disp_req==1.
REQ-013 change_coin  out  1  one-cycle pulse per 1-unit coin returned.
REQ-014 credit  out  5  current credit in units, registered.
REQ-015 sold_out  out  4  bit i high when slot i stock==0.
REQ-016 busy  out  1  high whenever state != CREDIT.
REQ-017 coin_reject  out  1  one-cycle pulse: coin not accepted.
REQ-018 sel_error  out  1  one-cycle pulse: selection refused.
REQ-019 disp_fault  out  1  one-cycle pulse: dispense timeout.

Function
REQ-020 FSM states CREDIT, DISPENSE, CHANGE; all outputs registered, one-cycle latency from input to effect.
REQ-021 Prices fixed: slot0 3, slot1 4, slot2 5, slot3 6 units.
REQ-022 CREDIT: valid coin adds value to credit; coin==11, or any sum >31, -> credit unchanged, coin_reject pulse.
REQ-023 CREDIT priority: cancel > sel_valid > coin; an input losing priority in a cycle is ignored, a losing coin pulses coin_reject.
REQ-024 cancel with credit>0 -> CHANGE; cancel with credit==0 -> no effect.
REQ-025 sel_valid with credit>=price and stock>0 -> credit-=price, latch disp_slot, -> DISPENSE; otherwise sel_error pulse, state and credit unchanged.
REQ-026 DISPENSE: disp_req=1; on disp_ack, slot stock decrements by 1, disp_req drops next cycle, -> CHANGE if credit>0 else CREDIT.
REQ-027 DISPENSE: timeout counter starts 0 on entry; if it reaches ACK_TIMEOUT without ack, credit+=price of disp_slot, disp_fault pulse, stock unchanged, -> CHANGE.
REQ-028 disp_ack outside DISPENSE is ignored.
REQ-029 CHANGE: each cycle change_coin=1 and credit-=1; when credit reaches 0 -> CREDIT; N units of credit yield exactly N consecutive pulses.
REQ-030 In DISPENSE and CHANGE, coins pulse coin_reject; sel_valid pulses sel_error; cancel ignored.
REQ-031 restock honoured only in CREDIT; in other states ignored; stock never wraps below 0 nor exceeds STOCK_INIT.
REQ-032 Credit never exceeds 31 nor underflows below 0.

Reset
REQ-033 On reset: state CREDIT, credit 0, every stock = STOCK_INIT, timeout counter 0, all pulse outputs 0, disp_req 0, disp_slot 0, sold_out 0, busy 0.
REQ-034 Reset mid-DISPENSE or mid-CHANGE abandons the operation; credit is lost and no refund pulses follow.

Structure
REQ-035 Package vend_pkg holds: state enum, coin encoding constants, price table, credit width (5), slot count (4).
REQ-036 Sub-module vend_stock holds the four stock counters, decrement/restock ports and sold_out generation.

Verification
REQ-037 Coins 10,10,01 (5 units), sel=2 -> credit 5->0, disp_req, ack after 3 cycles -> stock[2]=6, zero change_coin pulses.
REQ-038 Credit 7, sel=0, ack -> CHANGE, exactly 4 change_coin pulses, credit 0, busy low afterwards.
REQ-039 Credit 30, coin 10 -> coin_reject, credit stays 30; cancel -> 30 change_coin pulses.
REQ-040 Credit 2, sel=1 -> sel_error, credit 2, state CREDIT; sel to empty slot -> sel_error.
REQ-041 Credit 6, sel=3, no ack for 15 cycles -> disp_fault, credit restored 6, 6 change_coin pulses, stock[3] unchanged.
REQ-042 Seven purchases on slot 0 -> sold_out[0]=1; restock in CREDIT -> sold_out 0, stock 7; rst=0 mid-CHANGE -> credit 0 next cycle.
